// File: rtl/updown_blink_ctrl.sv
// Up/down blinker controller: press detection, hold-to-auto-repeat, saturating
// rate-level stepping, both-buttons return to default, and the LED toggle counter.
module updown_blink_ctrl #(
   parameter int BASE_HALF     = 128,
   parameter int LEVEL_W       = 3,
   parameter int DEFAULT_LEVEL = 3,
   parameter int HOLD_CYCLES   = 20,
   parameter int REPEAT_CYCLES = 5,
   parameter int CNT_W         = 21
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_up,
   input  logic               btn_down,
   output logic               led,
   output logic [LEVEL_W-1:0] level,
   output logic               level_chg,
   output logic               at_min,
   output logic               at_max
);

   localparam logic [LEVEL_W-1:0] MAX_LEVEL = '1;
   localparam logic [LEVEL_W-1:0] DEF_LVL   = LEVEL_W'(DEFAULT_LEVEL);
   localparam int                 HOLD_W    = $clog2(HOLD_CYCLES);
   localparam int                 REP_W     = $clog2(REPEAT_CYCLES + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [REP_W-1:0]   REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   BASE      = CNT_W'(BASE_HALF);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BOTH} state_t;

   state_t              state, state_nxt;
   logic                dir, dir_nxt;
   logic [LEVEL_W-1:0]  level_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic [REP_W-1:0]    rep_cnt, rep_nxt;
   logic [CNT_W-1:0]    per_cnt, half;
   logic                held;

   function automatic logic [LEVEL_W-1:0] sat_step(input logic [LEVEL_W-1:0] l,
                                                   input logic               up);
      if (up)
         return (l == MAX_LEVEL) ? l : l + LEVEL_W'(1);
      return (l == '0) ? l : l - LEVEL_W'(1);
   endfunction

   assign held   = dir ? btn_up : btn_down;
   assign half   = BASE >> level;
   assign at_min = (level == '0);
   assign at_max = (level == MAX_LEVEL);

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      level_nxt = level;
      hold_nxt  = hold_cnt;
      rep_nxt   = rep_cnt;
      case (state)
         IDLE: begin
            if (btn_up && btn_down) begin
               level_nxt = DEF_LVL;
               state_nxt = BOTH;
            end else if (btn_up || btn_down) begin
               dir_nxt   = btn_up;
               level_nxt = sat_step(level, btn_up);
               hold_nxt  = '0;
               state_nxt = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (btn_up && btn_down) begin
               level_nxt = DEF_LVL;
               state_nxt = BOTH;
            end else if (!held) begin
               state_nxt = IDLE;
            end else if (state == HOLD) begin
               if (hold_cnt == HOLD_LAST) begin
                  level_nxt = sat_step(level, dir);
                  rep_nxt   = '0;
                  state_nxt = REPEAT;
               end else begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end else if (rep_cnt == REP_LAST) begin
               level_nxt = sat_step(level, dir);
               rep_nxt   = '0;
            end else begin
               rep_nxt = rep_cnt + REP_W'(1);
            end
         end
         BOTH: begin
            if (!btn_up && !btn_down)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A level change restarts the half-period and holds led, overriding terminal count
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         dir       <= 1'b0;
         level     <= DEF_LVL;
         level_chg <= 1'b0;
         hold_cnt  <= '0;
         rep_cnt   <= '0;
         per_cnt   <= '0;
         led       <= 1'b0;
      end else begin
         state     <= state_nxt;
         dir       <= dir_nxt;
         level     <= level_nxt;
         level_chg <= (level_nxt != level);
         hold_cnt  <= hold_nxt;
         rep_cnt   <= rep_nxt;
         if (level_nxt != level) begin
            per_cnt <= '0;
         end else if (per_cnt == half - CNT_W'(1)) begin
            led     <= ~led;
            per_cnt <= '0;
         end else begin
            per_cnt <= per_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_updown_blink_ctrl.sv
// Bench for updown_blink_ctrl: a cycle model queues expected outputs per edge,
// each scenario task drains and compares them, plus directed spot checks.
module tb_updown_blink_ctrl;

   localparam int BASE_HALF     = 128;
   localparam int LEVEL_W       = 3;
   localparam int DEFAULT_LEVEL = 3;
   localparam int HOLD_CYCLES   = 20;
   localparam int REPEAT_CYCLES = 5;
   localparam int CNT_W         = 21;
   localparam int MAX_LEVEL     = (1 << LEVEL_W) - 1;
   localparam int S_IDLE = 0, S_HOLD = 1, S_REP = 2, S_BOTH = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               btn_up = 1'b0;
   logic               btn_down = 1'b0;
   logic               led, level_chg, at_min, at_max;
   logic [LEVEL_W-1:0] level;

   always #5 clk = ~clk;

   updown_blink_ctrl #(
      .BASE_HALF(BASE_HALF), .LEVEL_W(LEVEL_W), .DEFAULT_LEVEL(DEFAULT_LEVEL),
      .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .led(led), .level(level), .level_chg(level_chg), .at_min(at_min), .at_max(at_max)
   );

   // {level, led, level_chg, at_min, at_max}
   typedef logic [LEVEL_W+3:0] obs_t;
   obs_t exp_q[$];
   obs_t obs_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int m_state = S_IDLE, m_dir = 0, m_level = DEFAULT_LEVEL, m_led = 0;
   int m_chg = 0, m_hold = 0, m_rep = 0, m_per = 0;

   function automatic int sat(input int l, input int up);
      if (up != 0) return (l == MAX_LEVEL) ? l : l + 1;
      return (l == 0) ? 0 : l - 1;
   endfunction

   task automatic model_step(input logic u, input logic d, input logic r);
      int nl;
      int hp;
      if (!r) begin
         m_state = S_IDLE; m_dir = 0; m_level = DEFAULT_LEVEL; m_led = 0;
         m_chg = 0; m_hold = 0; m_rep = 0; m_per = 0;
      end else begin
         nl = m_level;
         if (m_state == S_IDLE) begin
            if (u && d) begin nl = DEFAULT_LEVEL; m_state = S_BOTH; end
            else if (u || d) begin
               m_dir = u ? 1 : 0; nl = sat(m_level, m_dir); m_hold = 0; m_state = S_HOLD;
            end
         end else if (m_state == S_BOTH) begin
            if (!u && !d) m_state = S_IDLE;
         end else begin
            if (u && d) begin nl = DEFAULT_LEVEL; m_state = S_BOTH; end
            else if (((m_dir != 0) ? u : d) == 1'b0) m_state = S_IDLE;
            else if (m_state == S_HOLD) begin
               if (m_hold == HOLD_CYCLES - 1) begin
                  nl = sat(m_level, m_dir); m_rep = 0; m_state = S_REP;
               end else m_hold++;
            end else begin
               if (m_rep == REPEAT_CYCLES - 1) begin nl = sat(m_level, m_dir); m_rep = 0; end
               else m_rep++;
            end
         end
         hp = BASE_HALF >> m_level;
         m_chg = (nl != m_level) ? 1 : 0;
         if (nl != m_level) m_per = 0;
         else if (m_per == hp - 1) begin m_led = 1 - m_led; m_per = 0; end
         else m_per++;
         m_level = nl;
      end
   endtask

   task automatic drive(input logic u, input logic d, input logic r);
      obs_t e;
      btn_up = u; btn_down = d; rst = r;
      model_step(u, d, r);
      e = {m_level[LEVEL_W-1:0], m_led[0], m_chg[0], m_level == 0, m_level == MAX_LEVEL};
      exp_q.push_back(e);
      @(posedge clk); #1;
      obs_q.push_back({level, led, level_chg, at_min, at_max});
   endtask

   task automatic run(input logic u, input logic d, input logic r, input int n);
      for (int i = 0; i < n; i++) drive(u, d, r);
   endtask

   task automatic test_reset;
      obs_t e, o;
      int   t1, t2, idx;
      logic pl;
      run(0, 0, 0, 3);
      n_cmp++;
      if ({level, led, level_chg} !== {LEVEL_W'(DEFAULT_LEVEL), 1'b0, 1'b0}) begin
         n_err++; $display("FAIL reset_state: got level=%0d led=%b chg=%b need level=%0d led=0 chg=0",
                           level, led, level_chg, DEFAULT_LEVEL);
      end
      run(0, 0, 1, 40);
      t1 = -1; t2 = -1; idx = -3; pl = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL reset_sb idx %0d: got %b need %b", idx, o, e); end
         if (idx >= 0 && o[3] !== pl) begin if (t1 < 0) t1 = idx; else if (t2 < 0) t2 = idx; end
         pl = o[3]; idx++;
      end
      n_cmp++;
      if (t1 != 15 || t2 - t1 != 16) begin
         n_err++; $display("FAIL reset_blink: toggles at %0d,%0d need 15,31", t1, t2);
      end
   endtask

   task automatic test_tap_up;
      obs_t e, o;
      int   t1, t2, idx;
      logic pl;
      pl = led;
      drive(1, 0, 1);
      n_cmp++;
      if (level !== 3'd4 || level_chg !== 1'b1) begin
         n_err++; $display("FAIL tap_step: got level=%0d chg=%b need 4,1", level, level_chg);
      end
      drive(0, 0, 1);
      n_cmp++;
      if (level_chg !== 1'b0) begin
         n_err++; $display("FAIL tap_pulse: got chg=%b need 0", level_chg);
      end
      run(0, 0, 1, 20);
      t1 = -1; t2 = -1; idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL tap_sb idx %0d: got %b need %b", idx, o, e); end
         if (o[3] !== pl) begin if (t1 < 0) t1 = idx; else if (t2 < 0) t2 = idx; end
         pl = o[3]; idx++;
      end
      n_cmp++;
      if (t1 != 8 || t2 != 16) begin
         n_err++; $display("FAIL tap_blink: toggles at %0d,%0d need 8,16", t1, t2);
      end
   endtask

   task automatic test_hold_down;
      obs_t e, o;
      int   chg;
      run(0, 0, 0, 1);
      run(0, 1, 1, 60);
      run(0, 0, 1, 2);
      chg = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL hold_down_sb: got %b need %b", o, e); end
         if (o[2] === 1'b1) chg++;
      end
      n_cmp++;
      if (chg != 3 || level !== '0 || at_min !== 1'b1) begin
         n_err++; $display("FAIL hold_down_sat: got chg=%0d level=%0d at_min=%b need 3,0,1",
                           chg, level, at_min);
      end
   endtask

   task automatic test_hold_up_max;
      obs_t e, o;
      int   chg;
      logic pl;
      run(1, 0, 1, 80);
      pl = led;
      drive(1, 0, 1);
      n_cmp++;
      if (led !== ~pl) begin
         n_err++; $display("FAIL max_blink: got led=%b need %b", led, ~pl);
      end
      run(0, 0, 1, 2);
      chg = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL hold_up_sb: got %b need %b", o, e); end
         if (o[2] === 1'b1) chg++;
      end
      n_cmp++;
      if (chg != 7 || level !== 3'd7 || at_max !== 1'b1) begin
         n_err++; $display("FAIL hold_up_sat: got chg=%0d level=%0d at_max=%b need 7,7,1",
                           chg, level, at_max);
      end
   endtask

   task automatic test_both;
      obs_t e, o;
      drive(0, 1, 1);
      drive(0, 0, 1);
      n_cmp++;
      if (level !== 3'd6) begin n_err++; $display("FAIL both_pre: got level=%0d need 6", level); end
      drive(1, 1, 1);
      n_cmp++;
      if (level !== 3'd3 || level_chg !== 1'b1) begin
         n_err++; $display("FAIL both_default: got level=%0d chg=%b need 3,1", level, level_chg);
      end
      run(1, 1, 1, 4);
      run(1, 0, 1, 30);
      n_cmp++;
      if (level !== 3'd3) begin n_err++; $display("FAIL both_partial: got level=%0d need 3", level); end
      run(0, 0, 1, 1);
      drive(1, 0, 1);
      n_cmp++;
      if (level !== 3'd4) begin n_err++; $display("FAIL both_fresh: got level=%0d need 4", level); end
      run(0, 0, 1, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL both_sb: got %b need %b", o, e); end
      end
   endtask

   task automatic test_reset_mid_repeat;
      obs_t e, o;
      run(0, 0, 0, 1);
      run(1, 0, 1, 22);
      n_cmp++;
      if (level !== 3'd5) begin n_err++; $display("FAIL rr_pre: got level=%0d need 5", level); end
      drive(1, 0, 0);
      n_cmp++;
      if (level !== 3'd3 || led !== 1'b0 || level_chg !== 1'b0) begin
         n_err++; $display("FAIL rr_reset: got level=%0d led=%b chg=%b need 3,0,0", level, led, level_chg);
      end
      drive(1, 0, 1);
      n_cmp++;
      if (level !== 3'd4 || level_chg !== 1'b1) begin
         n_err++; $display("FAIL rr_restep: got level=%0d chg=%b need 4,1", level, level_chg);
      end
      run(1, 0, 1, 19);
      n_cmp++;
      if (level !== 3'd4) begin n_err++; $display("FAIL rr_hold: got level=%0d need 4", level); end
      drive(1, 0, 1);
      n_cmp++;
      if (level !== 3'd5) begin n_err++; $display("FAIL rr_second: got level=%0d need 5", level); end
      run(0, 0, 1, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL rr_sb: got %b need %b", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_tap_up();
      test_hold_down();
      test_hold_up_max();
      test_both();
      test_reset_mid_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
